fifo_rd_stream_adapter: RTL and testbench
=========================================

Name: fifo_rd_stream_adapter

Overview:
- Read-side master for fifo_with_error_detection. Drains the FIFO through its rd_en/rd_data port, which has one-cycle read latency.
- Presents the words on a valid/ready stream through a 2-entry output buffer, so a consumer that accepts every cycle receives one word per cycle.
- Monitors the FIFO's underflow and parity_error flags, latches them into sticky status bits, and optionally halts draining on a parity error.

Parameters:
- DATA_WIDTH, 8, word width; must match the FIFO.
- CNT_WIDTH, 16, width of the delivered-word counter.
- HALT_ON_PERR, 1, 1 = stop issuing reads after a parity error until err_clr.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- drain_en  in  1  permits new FIFO reads
- fifo_rd_en  out  1  read strobe to the FIFO
- fifo_rd_data  in  DATA_WIDTH  FIFO read data, valid the cycle after an accepted read
- fifo_empty  in  1  FIFO empty flag
- fifo_underflow  in  1  FIFO underflow flag
- fifo_parity_error  in  1  FIFO parity error flag
- m_valid  out  1  output word valid
- m_data  out  DATA_WIDTH  output word
- m_ready  in  1  consumer accepts the word
- err_clr  in  1  clears the sticky errors and leaves HALT
- sticky_underflow  out  1  latched underflow
- sticky_parity  out  1  latched parity error
- halted  out  1  state == HALT
- word_cnt  out  CNT_WIDTH  words delivered (m_valid & m_ready), wraps

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - All outputs 0: fifo_rd_en, m_valid, m_data, sticky bits, halted, word_cnt.
  - occ=0, inflight=0, state=IDLE, buffer contents cleared.
  - Reset mid-operation discards buffered and in-flight words; the FIFO pointers are not touched.
- State machine (registered):
  - IDLE -> RUN when drain_en=1.
  - RUN -> IDLE when drain_en=0.
  - RUN -> HALT on a parity-error capture when HALT_ON_PERR=1.
  - HALT -> IDLE on err_clr=1 (re-enters RUN next cycle if drain_en=1).
- Definitions:
  - pop = m_valid & m_ready.
  - inflight = fifo_rd_en registered; the FIFO honoured the read because the issue rule requires !fifo_empty.
- Issue rule (combinational):
  - fifo_rd_en = (state==RUN) & !fifo_empty & ((occ + inflight - pop) <= 1).
  - This never reads an empty FIFO and never overruns the 2-entry buffer.
  - It sustains 1 word/cycle when m_ready is held high.
- Capture:
  - When inflight=1, fifo_rd_data is written at the buffer tail.
  - In-flight words are always captured, even after leaving RUN.
- Buffer:
  - 2-entry register FIFO (head/tail index, occ 0..2).
  - m_valid = (occ != 0); m_data = head entry, driven from a register with no combinational path from fifo_rd_data.
  - Capture and pop in the same cycle leave occ unchanged.
  - Data order is strictly preserved.
- Latency: first fifo_rd_en (cycle t) -> capture at t+1 edge -> m_valid=1 in cycle t+2.
- Backpressure: when m_ready=0, m_data and m_valid hold stable (AXI-stream rules); reads stop once occ + inflight reaches 2.
- word_cnt increments on pop, modulo 2^CNT_WIDTH.
- Sticky status:
  - sticky_underflow and sticky_parity are set when the corresponding FIFO flag is sampled high.
  - err_clr clears them; if set and clear occur in the same cycle, set wins.
  - sticky_underflow=1 indicates a second reader on the FIFO, which is a system error; the adapter continues operating.
- halted = (state==HALT). In HALT, no reads are issued; buffered words still drain to the consumer.

Decomposition:
- Shared package fifo_pkg:
  - state enum (IDLE, RUN, HALT).
  - DATA_WIDTH default constant shared with fifo_with_error_detection.
- Natural sub-module: stream_skid_buf2, the 2-entry valid/ready buffer with occ output. The adapter top holds the FSM, issue logic, counters and sticky bits.

Test Plan:
- Reset, then 4 words (0x11, 0x22, 0x33, 0x44) written to the FIFO, drain_en=1, m_ready=1:
  - first m_valid 2 cycles after the first fifo_rd_en.
  - words delivered in order on consecutive cycles.
  - word_cnt=4; fifo_underflow never asserted.
- Backpressure: 8 words, m_ready low for 5 cycles then high:
  - fifo_rd_en stops after occ + inflight = 2.
  - m_data holds 0x01 during the stall.
  - all 8 words arrive in order; no FIFO overflow or underflow.
- Empty FIFO with drain_en=1 for 10 cycles: fifo_rd_en stays 0, m_valid stays 0, sticky_underflow=0.
- Force fifo_parity_error=1 for 1 cycle with HALT_ON_PERR=1:
  - sticky_parity=1 and halted=1 the next cycle.
  - no further fifo_rd_en; buffered words still drain.
  - err_clr -> IDLE, then RUN; sticky_parity=0.
- drain_en dropped while one read is in flight: that word is still captured and delivered; no new reads are issued.
- rst_n asserted with occ=2: m_valid=0 and word_cnt=0 the next cycle, and no stale word appears after reset.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side adapter and its FIFO:
// draining-state encoding and the default word width.
package fifo_pkg;

    localparam int FIFO_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

endpackage

// File: rtl/fifo_rd_stream_adapter_if.sv
// Bundles the FIFO read port and the output valid/ready stream of the adapter.
// master is the adapter's view; slave is the FIFO-plus-consumer environment.
interface fifo_rd_stream_adapter_if
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH
);

    logic                  fifo_rd_en;
    logic [DATA_WIDTH-1:0] fifo_rd_data;
    logic                  fifo_empty;
    logic                  fifo_underflow;
    logic                  fifo_parity_error;

    logic                  m_valid;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_ready;

    modport master (
        output fifo_rd_en,
        input  fifo_rd_data,
        input  fifo_empty,
        input  fifo_underflow,
        input  fifo_parity_error,
        output m_valid,
        output m_data,
        input  m_ready
    );

    modport slave (
        input  fifo_rd_en,
        output fifo_rd_data,
        output fifo_empty,
        output fifo_underflow,
        output fifo_parity_error,
        input  m_valid,
        input  m_data,
        output m_ready
    );

endinterface

// File: rtl/fifo_rd_stream_adapter_buf.sv
// Two-entry register FIFO presenting words on a valid/ready stream.
// out_data comes straight from storage, so there is no path from wr_data to out_data.
module stream_skid_buf2 #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    output logic [1:0]            occ
);

    logic [DATA_WIDTH-1:0] mem [2];
    logic                  head;
    logic                  tail;
    logic [1:0]            count;
    logic                  pop;
    logic                  wr_accept;

    assign pop       = out_valid & out_ready;
    // With both slots full a write is only legal when the head leaves this cycle.
    assign wr_accept = wr_en & ((count != 2'd2) | pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            head   <= 1'b0;
            tail   <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (wr_accept) begin
                mem[tail] <= wr_data;
                tail      <= ~tail;
            end
            if (pop) begin
                head <= ~head;
            end
            case ({wr_accept, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign out_valid = (count != 2'd0);
    assign out_data  = mem[head];
    assign occ       = count;

endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// Read-side master for fifo_with_error_detection: drains the FIFO into a 2-entry
// stream buffer, counts delivered words and latches FIFO error flags.
module fifo_rd_stream_adapter
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH   = FIFO_DATA_WIDTH,
    parameter int CNT_WIDTH    = 16,
    parameter bit HALT_ON_PERR = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   drain_en,
    input  logic                   err_clr,
    fifo_rd_stream_adapter_if.master bus,
    output logic                   sticky_underflow,
    output logic                   sticky_parity,
    output logic                   halted,
    output logic [CNT_WIDTH-1:0]   word_cnt
);

    state_t     state;
    state_t     state_next;
    logic       inflight;
    logic       pop;
    logic       rd_issue;
    logic [1:0] occ;
    logic [2:0] slots_after;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A parity error outranks a drain_en drop so the fault is never missed.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (drain_en) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (HALT_ON_PERR && bus.fifo_parity_error) begin
                    state_next = HALT;
                end else if (!drain_en) begin
                    state_next = IDLE;
                end
            end
            HALT: begin
                if (err_clr) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign pop = bus.m_valid & bus.m_ready;

    // Slots still claimed after this cycle; issue only if one stays free.
    assign slots_after = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    assign rd_issue    = (state == RUN) & ~bus.fifo_empty & (slots_after <= 3'd1);
    assign bus.fifo_rd_en = rd_issue;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inflight <= 1'b0;
        end else begin
            inflight <= rd_issue;
        end
    end

    stream_skid_buf2 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (inflight),
        .wr_data   (bus.fifo_rd_data),
        .out_valid (bus.m_valid),
        .out_data  (bus.m_data),
        .out_ready (bus.m_ready),
        .occ       (occ)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sticky_underflow <= 1'b0;
            sticky_parity    <= 1'b0;
        end else begin
            if (bus.fifo_underflow) begin
                sticky_underflow <= 1'b1;
            end else if (err_clr) begin
                sticky_underflow <= 1'b0;
            end
            if (bus.fifo_parity_error) begin
                sticky_parity <= 1'b1;
            end else if (err_clr) begin
                sticky_parity <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            word_cnt <= '0;
        end else if (pop) begin
            word_cnt <= word_cnt + 1'b1;
        end
    end

    assign halted = (state == HALT);

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Bench for fifo_rd_stream_adapter: a behavioural FIFO feeds the DUT and a
// scoreboard queue of written words is checked against every delivered word.
module tb_fifo_rd_stream_adapter;
    import fifo_pkg::*;

    localparam int DW = 8;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          drain_en = 1'b0;
    logic          err_clr = 1'b0;
    logic          sticky_underflow;
    logic          sticky_parity;
    logic          halted;
    logic [CW-1:0] word_cnt;

    fifo_rd_stream_adapter_if #(.DATA_WIDTH(DW)) bus ();

    fifo_rd_stream_adapter #(
        .DATA_WIDTH   (DW),
        .CNT_WIDTH    (CW),
        .HALT_ON_PERR (1'b1)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .drain_en         (drain_en),
        .err_clr          (err_clr),
        .bus              (bus.master),
        .sticky_underflow (sticky_underflow),
        .sticky_parity    (sticky_parity),
        .halted           (halted),
        .word_cnt         (word_cnt)
    );

    always #5 clk = ~clk;

    int checkCount = 0;
    int passCount  = 0;

    logic [DW-1:0] wrQ[$];
    logic [DW-1:0] fifoQ[$];
    logic [DW-1:0] expQ[$];

    logic          modelEmpty = 1'b1;
    logic          modelUnderflow = 1'b0;
    logic [DW-1:0] modelRdData = '0;

    assign bus.fifo_empty     = modelEmpty;
    assign bus.fifo_underflow = modelUnderflow;
    assign bus.fifo_rd_data   = modelRdData;

    // One-cycle-latency FIFO; its contents survive adapter resets.
    always @(posedge clk) begin
        logic [DW-1:0] w;
        if (bus.fifo_rd_en === 1'b1) begin
            if (fifoQ.size() > 0) begin
                w = fifoQ.pop_front();
                modelRdData    <= w;
                modelUnderflow <= 1'b0;
            end else begin
                modelUnderflow <= 1'b1;
            end
        end else begin
            modelUnderflow <= 1'b0;
        end
        while (wrQ.size() > 0) begin
            fifoQ.push_back(wrQ.pop_front());
        end
        modelEmpty <= (fifoQ.size() == 0);
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [DW-1:0] word);
        wrQ.push_back(word);
        expQ.push_back(word);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic waitUntilLeft(input int left, input int maxCycles);
        int n = 0;
        while ((expQ.size() > left || bus.m_valid) && n < maxCycles) begin
            @(negedge clk);
            n++;
        end
        if (n >= maxCycles) begin
            checkCount++;
            $display("[TB] FAIL drain timeout: %0d words still expected, wanted %0d", expQ.size(), left);
        end
    endtask

    // Scoreboard monitor: every handshake must deliver the oldest expected word.
    always @(negedge clk) begin
        logic [DW-1:0] expWord;
        if (rst_n && bus.m_valid && bus.m_ready) begin
            if (expQ.size() == 0) begin
                checkCount++;
                $display("[TB] FAIL unexpected word: got 0x%0h, expected none", bus.m_data);
            end else begin
                expWord = expQ.pop_front();
                checkOutput("stream data", 32'(bus.m_data), 32'(expWord));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, %0d checks done", checkCount);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int firstRd;
        int firstValid;
        int lastValid;
        int validCycles;
        int rdCount;
        int mdataBad;
        bit rdSeen;

        bus.m_ready = 1'b0;
        bus.fifo_parity_error = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        checkOutput("reset fifo_rd_en", 32'(bus.fifo_rd_en), 32'd0);
        checkOutput("reset m_valid", 32'(bus.m_valid), 32'd0);
        checkOutput("reset m_data", 32'(bus.m_data), 32'd0);
        checkOutput("reset sticky", 32'({sticky_underflow, sticky_parity}), 32'd0);
        checkOutput("reset halted", 32'(halted), 32'd0);
        checkOutput("reset word_cnt", 32'(word_cnt), 32'd0);
        tick();
        rst_n = 1'b1;

        $display("[TB] basic drain of four words");
        tick();
        bus.m_ready = 1'b1;
        drain_en = 1'b1;
        applyStimulus(8'h11);
        applyStimulus(8'h22);
        applyStimulus(8'h33);
        applyStimulus(8'h44);
        firstRd = -1;
        firstValid = -1;
        lastValid = -1;
        validCycles = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.fifo_rd_en && firstRd < 0) firstRd = c;
            if (bus.m_valid) begin
                if (firstValid < 0) firstValid = c;
                lastValid = c;
                validCycles++;
            end
        end
        checkOutput("first valid latency", 32'(firstValid - firstRd), 32'd2);
        checkOutput("valid cycles", 32'(validCycles), 32'd4);
        checkOutput("valid run length", 32'(lastValid - firstValid), 32'd3);
        checkOutput("word_cnt after 4", 32'(word_cnt), 32'd4);
        checkOutput("no underflow", 32'(sticky_underflow), 32'd0);

        $display("[TB] backpressure with eight words");
        tick();
        bus.m_ready = 1'b0;
        for (int i = 1; i <= 8; i++) applyStimulus(8'(i));
        rdCount = 0;
        mdataBad = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.fifo_rd_en) rdCount++;
            if (bus.m_valid && bus.m_data != 8'h01) mdataBad++;
        end
        checkOutput("reads during stall", 32'(rdCount), 32'd2);
        checkOutput("stall m_valid", 32'(bus.m_valid), 32'd1);
        checkOutput("stall m_data", 32'(bus.m_data), 32'h01);
        checkOutput("stall m_data changes", 32'(mdataBad), 32'd0);
        tick();
        bus.m_ready = 1'b1;
        waitUntilLeft(0, 60);
        tick();
        @(negedge clk);
        checkOutput("word_cnt after 12", 32'(word_cnt), 32'd12);
        checkOutput("no underflow after stall", 32'(sticky_underflow), 32'd0);

        $display("[TB] empty FIFO with drain enabled");
        rdCount = 0;
        validCycles = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.fifo_rd_en) rdCount++;
            if (bus.m_valid) validCycles++;
        end
        checkOutput("empty reads", 32'(rdCount), 32'd0);
        checkOutput("empty valids", 32'(validCycles), 32'd0);
        checkOutput("empty underflow", 32'(sticky_underflow), 32'd0);

        $display("[TB] parity error halts draining");
        tick();
        for (int i = 0; i < 6; i++) applyStimulus(8'h51 + 8'(i));
        repeat (3) tick();
        bus.fifo_parity_error = 1'b1;
        tick();
        bus.fifo_parity_error = 1'b0;
        @(negedge clk);
        checkOutput("parity sticky", 32'(sticky_parity), 32'd1);
        checkOutput("parity halted", 32'(halted), 32'd1);
        rdCount = 0;
        for (int c = 0; c < 6; c++) begin
            if (bus.fifo_rd_en) rdCount++;
            @(negedge clk);
        end
        checkOutput("reads while halted", 32'(rdCount), 32'd0);
        checkOutput("still halted", 32'(halted), 32'd1);
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        @(negedge clk);
        checkOutput("parity cleared", 32'(sticky_parity), 32'd0);
        checkOutput("halt left", 32'(halted), 32'd0);
        waitUntilLeft(0, 60);
        tick();
        @(negedge clk);
        checkOutput("word_cnt after 18", 32'(word_cnt), 32'd18);

        $display("[TB] drain_en dropped with a read in flight");
        tick();
        applyStimulus(8'h77);
        rdSeen = 1'b0;
        for (int c = 0; c < 10 && !rdSeen; c++) begin
            @(negedge clk);
            if (bus.fifo_rd_en) rdSeen = 1'b1;
        end
        checkOutput("read issued", 32'(rdSeen), 32'd1);
        tick();
        drain_en = 1'b0;
        tick();
        applyStimulus(8'h88);
        rdCount = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.fifo_rd_en) rdCount++;
        end
        checkOutput("reads after drop", 32'(rdCount), 32'd0);
        waitUntilLeft(1, 30);
        tick();
        @(negedge clk);
        checkOutput("word_cnt after 19", 32'(word_cnt), 32'd19);

        $display("[TB] reset with a full buffer");
        tick();
        bus.m_ready = 1'b0;
        drain_en = 1'b1;
        applyStimulus(8'h91);
        applyStimulus(8'h92);
        applyStimulus(8'h93);
        repeat (8) tick();
        @(negedge clk);
        checkOutput("full m_valid", 32'(bus.m_valid), 32'd1);
        checkOutput("full m_data", 32'(bus.m_data), 32'h88);
        tick();
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        checkOutput("mid reset m_valid", 32'(bus.m_valid), 32'd0);
        checkOutput("mid reset word_cnt", 32'(word_cnt), 32'd0);
        checkOutput("mid reset fifo_rd_en", 32'(bus.fifo_rd_en), 32'd0);
        // 0x88 and 0x91 sat in the buffer and are lost by the reset
        void'(expQ.pop_front());
        void'(expQ.pop_front());
        tick();
        rst_n = 1'b1;
        bus.m_ready = 1'b1;
        waitUntilLeft(0, 40);
        tick();
        @(negedge clk);
        checkOutput("word_cnt after reset", 32'(word_cnt), 32'd2);
        checkOutput("final underflow", 32'(sticky_underflow), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
